// File: rtl/dsc_pkg.sv
// Shared types for the DSC datapath: decoder FSM states, common to both ends of the link.
package dsc_pkg;

   typedef enum logic [1:0] {
      DEC_IDLE  = 2'd0,
      DEC_ACCUM = 2'd1,
      DEC_HOLD  = 2'd2
   } dec_state_t;

endpackage : dsc_pkg

// File: rtl/dsc_sn_decoder_counter.sv
// Up-counter with asynchronous active-low reset, synchronous clear and enable.
// Wraps naturally at 2^WIDTH; callers detect the wrap themselves if they care.
module dsc_sn_decoder_counter #(
   parameter int WIDTH  = 16,
   parameter int STRIDE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] STEP = WIDTH'(STRIDE);

   // Count register: clear has priority over increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + STEP;
      end
   end

endmodule : dsc_sn_decoder_counter

// File: rtl/dsc_sn_decoder.sv
// Stochastic bitstream decoder: counts ones and valid beats over a programmable window
// (or until an early stop), then holds the result until the consumer takes it.
module dsc_sn_decoder
   import dsc_pkg::*;
#(
   parameter int WXIP1      = 16,
   parameter int MIN_WINDOW = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WXIP1-1:0] window_len,
   input  logic             stop,
   input  logic             sn_valid,
   input  logic             sn_bit,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WXIP1-1:0] bin_out,
   output logic [WXIP1-1:0] cycles_out,
   output logic             overflow
);

   localparam logic [WXIP1-1:0] MIN_W = WXIP1'(MIN_WINDOW);
   localparam logic [WXIP1-1:0] ONE   = WXIP1'(1);

   dec_state_t       state;
   dec_state_t       state_nxt;
   logic [WXIP1-1:0] window_q;
   logic             overflow_q;

   logic             start_idle;
   logic             beat_en;
   logic             ones_en;
   logic             terminal;
   logic             beat_wrap;

   // True once a count has reached its maximum representable value.
   function automatic logic is_saturated(input logic [WXIP1-1:0] v);
      return &v;
   endfunction

   // Zero means "unbounded"; any other request is raised to the minimum legal window.
   function automatic logic [WXIP1-1:0] clamp_window(input logic [WXIP1-1:0] wl);
      if (wl == '0) begin
         return '0;
      end else if (wl < MIN_W) begin
         return MIN_W;
      end else begin
         return wl;
      end
   endfunction

   assign start_idle = start && (state == DEC_IDLE);
   assign beat_en    = (state == DEC_ACCUM) && sn_valid;
   // Ones stop counting at all-ones so an unbounded run never wraps the result.
   assign ones_en    = beat_en && sn_bit && !is_saturated(bin_out);
   // The beat being counted this edge is the last one of a bounded window.
   assign terminal   = beat_en && (window_q != '0) && (cycles_out == (window_q - ONE));
   assign beat_wrap  = beat_en && is_saturated(cycles_out);

   assign busy      = (state == DEC_ACCUM);
   assign out_valid = (state == DEC_HOLD);
   assign overflow  = overflow_q;

   dsc_sn_decoder_counter #(
      .WIDTH  (WXIP1),
      .STRIDE (1)
   ) u_beat_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start_idle),
      .en    (beat_en),
      .count (cycles_out)
   );

   dsc_sn_decoder_counter #(
      .WIDTH  (WXIP1),
      .STRIDE (1)
   ) u_ones_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start_idle),
      .en    (ones_en),
      .count (bin_out)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= DEC_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: terminal beat and stop share one path into HOLD.
   always_comb begin
      state_nxt = state;
      case (state)
         DEC_IDLE: begin
            if (start) begin
               state_nxt = DEC_ACCUM;
            end
         end
         DEC_ACCUM: begin
            if (terminal || stop) begin
               state_nxt = DEC_HOLD;
            end
         end
         DEC_HOLD: begin
            if (out_ready) begin
               state_nxt = DEC_IDLE;
            end
         end
         default: begin
            state_nxt = DEC_IDLE;
         end
      endcase
   end

   // Window latch, captured only on an accepted start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         window_q <= '0;
      end else if (start_idle) begin
         window_q <= clamp_window(window_len);
      end
   end

   // Sticky overflow: set when the beat counter wraps, cleared by the next start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
      end else if (start_idle) begin
         overflow_q <= 1'b0;
      end else if (beat_wrap) begin
         overflow_q <= 1'b1;
      end
   end

endmodule : dsc_sn_decoder

// File: tb/tb_dsc_sn_decoder.sv
// Directed bench for dsc_sn_decoder: scoreboard queues filled by stimulus, drained by a monitor.
module tb_dsc_sn_decoder;

   typedef struct {
      logic [15:0] bin;
      logic [15:0] cyc;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   // 16-bit instance
   logic        a_start = 0, a_stop = 0, a_sn_valid = 0, a_sn_bit = 0, a_out_ready = 1;
   logic [15:0] a_window_len = 0;
   logic        a_busy, a_out_valid, a_overflow;
   logic [15:0] a_bin_out, a_cycles_out;

   // 4-bit instance, minimum window 3
   logic        b_start = 0, b_stop = 0, b_sn_valid = 0, b_sn_bit = 0, b_out_ready = 1;
   logic [3:0]  b_window_len = 0;
   logic        b_busy, b_out_valid, b_overflow;
   logic [3:0]  b_bin_out, b_cycles_out;

   exp_t qa[$];
   exp_t qb[$];
   int   total = 0;
   int   bad = 0;

   dsc_sn_decoder #(.WXIP1(16), .MIN_WINDOW(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .window_len(a_window_len), .stop(a_stop),
      .sn_valid(a_sn_valid), .sn_bit(a_sn_bit), .busy(a_busy), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .bin_out(a_bin_out), .cycles_out(a_cycles_out),
      .overflow(a_overflow)
   );

   dsc_sn_decoder #(.WXIP1(4), .MIN_WINDOW(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .window_len(b_window_len), .stop(b_stop),
      .sn_valid(b_sn_valid), .sn_bit(b_sn_bit), .busy(b_busy), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .bin_out(b_bin_out), .cycles_out(b_cycles_out),
      .overflow(b_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic push_a(input logic [15:0] bin, input logic [15:0] cyc, input logic ovf);
      exp_t e;
      e.bin = bin; e.cyc = cyc; e.ovf = ovf;
      qa.push_back(e);
   endtask

   task automatic push_b(input logic [15:0] bin, input logic [15:0] cyc, input logic ovf);
      exp_t e;
      e.bin = bin; e.cyc = cyc; e.ovf = ovf;
      qb.push_back(e);
   endtask

   // Pulse start for one edge; returns 1ns after the start edge.
   task automatic start_a(input logic [15:0] wl);
      @(posedge clk); #1;
      a_start = 1; a_window_len = wl;
      @(posedge clk); #1;
      a_start = 0;
   endtask

   // Feed beats to instance A; edges = edges from start edge (inclusive) until out_valid.
   task automatic feed_a(input int max_clk, input bit toggle, input int ones_beats,
                         input int stop_at, input bit expect_done, output int edges);
      int b = 0;
      edges = 0;
      for (int c = 0; c < max_clk; c++) begin
         a_sn_valid = toggle ? (c % 2 == 0) : 1'b1;
         a_sn_bit   = (b < ones_beats);
         a_stop     = a_sn_valid && (b == stop_at);
         @(posedge clk);
         if (a_sn_valid) b++;
         #1;
         if (a_out_valid) begin
            edges = c + 2;
            break;
         end
      end
      a_sn_valid = 0; a_sn_bit = 0; a_stop = 0;
      if (expect_done && edges == 0) begin
         total++; bad++;
         $display("FAIL feed_a_timeout actual=no out_valid expected=out_valid within %0d clks", max_clk);
      end
   endtask

   // Feed an all-ones stream to instance B with stop on beat index stop_at.
   task automatic feed_b(input int max_clk, input int stop_at);
      bit done = 0;
      for (int c = 0; c < max_clk; c++) begin
         b_sn_valid = 1; b_sn_bit = 1;
         b_stop = (c == stop_at);
         @(posedge clk); #1;
         if (b_out_valid) begin
            done = 1;
            break;
         end
      end
      b_sn_valid = 0; b_sn_bit = 0; b_stop = 0;
      if (!done) begin
         total++; bad++;
         $display("FAIL feed_b_timeout actual=no out_valid expected=out_valid within %0d clks", max_clk);
      end
   endtask

   // Scoreboard monitor: compare each result as it is handed off.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && a_out_valid && a_out_ready) begin
         total++;
         if (qa.size() == 0) begin
            bad++;
            $display("FAIL sb_a unexpected result bin=%0d cyc=%0d ovf=%0d", a_bin_out, a_cycles_out, a_overflow);
         end else begin
            e = qa.pop_front();
            if (a_bin_out !== e.bin || a_cycles_out !== e.cyc || a_overflow !== e.ovf) begin
               bad++;
               $display("FAIL sb_a actual bin=%0d cyc=%0d ovf=%0d expected bin=%0d cyc=%0d ovf=%0d",
                        a_bin_out, a_cycles_out, a_overflow, e.bin, e.cyc, e.ovf);
            end
         end
      end
      if (rst_n && b_out_valid && b_out_ready) begin
         total++;
         if (qb.size() == 0) begin
            bad++;
            $display("FAIL sb_b unexpected result bin=%0d cyc=%0d ovf=%0d", b_bin_out, b_cycles_out, b_overflow);
         end else begin
            e = qb.pop_front();
            if ({12'h0, b_bin_out} !== e.bin || {12'h0, b_cycles_out} !== e.cyc || b_overflow !== e.ovf) begin
               bad++;
               $display("FAIL sb_b actual bin=%0d cyc=%0d ovf=%0d expected bin=%0d cyc=%0d ovf=%0d",
                        b_bin_out, b_cycles_out, b_overflow, e.bin, e.cyc, e.ovf);
            end
         end
      end
   end

   // Watchdog against a hung run.
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int edges;

      // Reset state
      #3;
      chk("rst_busy", a_busy, 0);
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_bin", a_bin_out, 0);
      chk("rst_cycles", a_cycles_out, 0);
      chk("rst_overflow", a_overflow, 0);
      chk("rst_b_outs", {b_busy, b_out_valid, b_overflow, b_bin_out, b_cycles_out}, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1;

      // Window 16, ones on beats 0-3
      push_a(16'd4, 16'd16, 1'b0);
      start_a(16'd16);
      chk("t1_busy", a_busy, 1);
      feed_a(40, 0, 4, -1, 1, edges);
      chk("t1_latency", edges, 17);

      // Window 8, sn_valid toggling
      push_a(16'd3, 16'd8, 1'b0);
      start_a(16'd8);
      feed_a(40, 1, 3, -1, 1, edges);
      chk("t2_latency", edges, 16);

      // Unbounded, all ones, stop on beat 100
      push_a(16'd100, 16'd100, 1'b0);
      start_a(16'd0);
      feed_a(200, 0, 1000, 99, 1, edges);
      chk("t3_latency", edges, 101);

      // Narrow counter: wrap of beats, saturation of ones
      push_b(16'd15, 16'd4, 1'b1);
      @(posedge clk); #1;
      b_start = 1; b_window_len = 4'd0;
      @(posedge clk); #1;
      b_start = 0;
      chk("t4_b_busy", b_busy, 1);
      feed_b(40, 19);

      // Window below minimum is raised to 3; overflow cleared by start
      push_b(16'd3, 16'd3, 1'b0);
      @(posedge clk); #1;
      b_start = 1; b_window_len = 4'd1;
      @(posedge clk); #1;
      b_start = 0;
      chk("t4_b_ovf_cleared", b_overflow, 0);
      feed_b(40, -1);

      // Stop coincident with terminal beat, then a long hold with start ignored
      a_out_ready = 0;
      push_a(16'd2, 16'd5, 1'b0);
      start_a(16'd5);
      feed_a(40, 0, 2, 4, 1, edges);
      chk("t5_latency", edges, 6);
      a_sn_valid = 1; a_sn_bit = 1;
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            a_start = 1; a_window_len = 16'd3;
         end else begin
            a_start = 0;
         end
         @(posedge clk); #1;
         chk("t5_hold", {a_out_valid, a_busy, a_bin_out, a_cycles_out}, {1'b1, 1'b0, 16'd2, 16'd5});
      end
      a_start = 0; a_sn_valid = 0; a_sn_bit = 0;
      a_out_ready = 1;
      @(posedge clk); #1;
      chk("t5_released", a_out_valid, 0);
      chk("t5_retained", {a_bin_out, a_cycles_out}, {16'd2, 16'd5});

      // Reset in the middle of accumulation, then a clean window
      start_a(16'd32);
      feed_a(7, 0, 32, -1, 0, edges);
      chk("t6_pre_reset_cycles", a_cycles_out, 7);
      rst_n = 0;
      #1;
      chk("t6_rst_busy", a_busy, 0);
      chk("t6_rst_valid", a_out_valid, 0);
      chk("t6_rst_counts", {a_bin_out, a_cycles_out}, 0);
      chk("t6_rst_ovf", a_overflow, 0);
      @(negedge clk);
      rst_n = 1;
      push_a(16'd10, 16'd32, 1'b0);
      start_a(16'd32);
      feed_a(60, 0, 10, -1, 1, edges);
      chk("t6_latency", edges, 33);

      repeat (4) @(posedge clk);
      #1;
      chk("sb_a_drained", qa.size(), 0);
      chk("sb_b_drained", qb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_dsc_sn_decoder
